// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x oversampling UART receiver (1 start, DATA_BITS data LSB first,
// 1 stop, no parity). Good words pulse rx_done_tick; a low stop bit pulses frame_err.
module uart_rx_unit #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16,
  parameter int DVSR      = 326
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 frame_err
);
  localparam int SMAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int NW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CW   = $clog2(DVSR);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s, tick;

  assign rx_s         = sync_q[1];
  assign tick         = (cnt_q == CW'(DVSR - 1));
  assign rx_data      = data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

  // Synchroniser shift and free-running baud counter (never restarted by frames)
  always_comb begin
    sync_d = {sync_q[0], rx};
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
  end

  // Receive FSM: next state, counters, shift register and output pulses
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // start-bit detection runs every clk, not just on ticks
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == SW'(7)) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;  // glitch shorter than half a bit
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DATA_BITS-1:1]};
            if (n_q == NW'(DATA_BITS - 1)) state_d = STOP;
            else                           n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            if (rx_s) begin
              data_d  = b_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      BRK: begin
        // a held-low line only reports one error; wait for it to return high
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end
endmodule
